// File: rtl/fm_tx_ctrl.sv
// FM transmit sequencer: amplitude ramp, mute-before-retune, settle delay and audio-loss watchdog.
// All outputs registered (one cycle after accept); cfg_ready only in OFF/RUN, the source holds cfg_valid otherwise.
module fm_tx_ctrl #(
  parameter int unsigned     N           = 18,
  parameter int unsigned     L           = 12,
  parameter int unsigned     D           = 4,
  parameter logic [N-1:0]    RST_ACC_INC = 18'd52429,
  parameter int unsigned     RAMP_CYC    = 1024,
  parameter int unsigned     SETTLE      = 4096,
  parameter int unsigned     TO_W        = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [N-1:0] cfg_acc_inc,
  input  logic [L-1:0] cfg_df_inc,
  input  logic [D-1:0] cfg_dac_ena,
  input  logic         cfg_tx_en,
  input  logic         audio_dv,
  output logic [N-1:0] acc_inc,
  output logic [L-1:0] df_inc,
  output logic [D-1:0] dac_ena,
  output logic         mute,
  output logic [2:0]   state
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_RUN       = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_RETUNE    = 3'd4
  } state_t;

  localparam int unsigned CMAX = (RAMP_CYC > SETTLE) ? RAMP_CYC : SETTLE;
  localparam int unsigned CW   = ($clog2(CMAX) < 1) ? 1 : $clog2(CMAX);
  localparam logic [CW-1:0]   RAMP_LAST   = CW'(RAMP_CYC - 1);
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [TO_W-1:0] WD_MAX      = '1;

  state_t          st_q, st_nx;
  logic [CW-1:0]   cnt_q, cnt_nx;
  logic [D-1:0]    mask_q, mask_nx;
  logic [TO_W-1:0] wd_q, wd_nx;
  logic [L-1:0]    df_sh_q, df_sh_nx;
  logic [D-1:0]    ena_sh_q, ena_sh_nx;
  logic            tx_sh_q, tx_sh_nx;
  logic [N-1:0]    pend_q, pend_nx;
  logic [N-1:0]    acc_nx;
  logic [L-1:0]    df_nx;
  logic [D-1:0]    ena_nx;
  logic            mute_nx;
  logic            accept;

  assign cfg_ready = (st_q == S_OFF) || (st_q == S_RUN);
  assign accept    = cfg_valid & cfg_ready;
  assign state     = st_q;

  always_comb begin
    st_nx     = st_q;
    cnt_nx    = cnt_q;
    mask_nx   = mask_q;
    df_sh_nx  = df_sh_q;
    ena_sh_nx = ena_sh_q;
    tx_sh_nx  = tx_sh_q;
    pend_nx   = pend_q;
    acc_nx    = acc_inc;

    if (accept) begin
      df_sh_nx  = cfg_df_inc;
      ena_sh_nx = cfg_dac_ena;
      tx_sh_nx  = cfg_tx_en;
      pend_nx   = cfg_acc_inc;
    end

    // Clear has priority over saturation so a fresh sample always unmutes.
    if (audio_dv)            wd_nx = '0;
    else if (wd_q == WD_MAX) wd_nx = wd_q;
    else                     wd_nx = wd_q + 1'b1;
    mute_nx = (wd_nx == WD_MAX);

    unique case (st_q)
      S_OFF: begin
        if (accept) begin
          acc_nx = cfg_acc_inc;
          if (cfg_tx_en) begin
            st_nx  = S_RAMP_UP;
            cnt_nx = '0;
          end
        end
      end
      S_RAMP_UP: begin
        if (cnt_q == RAMP_LAST) begin
          cnt_nx  = '0;
          mask_nx = {1'b1, mask_q[D-1:1]};
          if (&mask_nx) st_nx = S_RUN;
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (accept && (!cfg_tx_en || (cfg_acc_inc != acc_inc))) begin
          st_nx  = S_RAMP_DOWN;
          cnt_nx = '0;
        end
      end
      S_RAMP_DOWN: begin
        if (cnt_q == RAMP_LAST) begin
          cnt_nx  = '0;
          mask_nx = {mask_q[D-2:0], 1'b0};
          if (mask_nx == '0) begin
            if (tx_sh_q) begin
              st_nx  = S_RETUNE;
              acc_nx = pend_q;
            end else begin
              st_nx = S_OFF;
            end
          end
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end
      S_RETUNE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_nx = '0;
          st_nx  = S_RAMP_UP;
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end
      default: begin
        st_nx   = S_OFF;
        cnt_nx  = '0;
        mask_nx = '0;
      end
    endcase

    // Outputs are derived from next-cycle state so they register alongside it.
    df_nx  = ((st_nx == S_RUN) && !mute_nx) ? df_sh_nx : '0;
    ena_nx = ena_sh_nx & mask_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q     <= S_OFF;
      cnt_q    <= '0;
      mask_q   <= '0;
      wd_q     <= '0;
      df_sh_q  <= '0;
      ena_sh_q <= '0;
      tx_sh_q  <= 1'b0;
      pend_q   <= RST_ACC_INC;
      acc_inc  <= RST_ACC_INC;
      df_inc   <= '0;
      dac_ena  <= '0;
      mute     <= 1'b0;
    end else begin
      st_q     <= st_nx;
      cnt_q    <= cnt_nx;
      mask_q   <= mask_nx;
      wd_q     <= wd_nx;
      df_sh_q  <= df_sh_nx;
      ena_sh_q <= ena_sh_nx;
      tx_sh_q  <= tx_sh_nx;
      pend_q   <= pend_nx;
      acc_inc  <= acc_nx;
      df_inc   <= df_nx;
      dac_ena  <= ena_nx;
      mute     <= mute_nx;
    end
  end

endmodule

// File: tb/tb_fm_tx_ctrl.sv
// Directed plus randomized bench for fm_tx_ctrl against a cycle-counting reference model.
module tb_fm_tx_ctrl;
  localparam int N = 18, L = 12, D = 4, RC = 4, ST = 8, TW = 4;
  localparam int WDMAX = (1 << TW) - 1;
  localparam logic [N-1:0] RST_ACC = 18'd52429;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [N-1:0] cfg_acc_inc;
  logic [L-1:0] cfg_df_inc;
  logic [D-1:0] cfg_dac_ena;
  logic         cfg_tx_en;
  logic         audio_dv;
  logic [N-1:0] acc_inc;
  logic [L-1:0] df_inc;
  logic [D-1:0] dac_ena;
  logic         mute;
  logic [2:0]   state;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int aud_per = 0;

  // Reference model: mode number, cycles spent in mode, cycles since last audio sample.
  int           m_mode, m_el, m_since;
  logic [N-1:0] m_acc, m_pend;
  logic [L-1:0] m_df;
  logic [D-1:0] m_ena;
  bit           m_tx, m_mute, m_accepted;

  always #5 clk = ~clk;

  fm_tx_ctrl #(
    .N(N), .L(L), .D(D), .RST_ACC_INC(RST_ACC),
    .RAMP_CYC(RC), .SETTLE(ST), .TO_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_acc_inc(cfg_acc_inc), .cfg_df_inc(cfg_df_inc),
    .cfg_dac_ena(cfg_dac_ena), .cfg_tx_en(cfg_tx_en),
    .audio_dv(audio_dv),
    .acc_inc(acc_inc), .df_inc(df_inc), .dac_ena(dac_ena),
    .mute(mute), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [D-1:0] mask_of(input int ones);
    int v;
    if (ones <= 0) return '0;
    v = ((1 << ones) - 1) << (D - ones);
    return v[D-1:0];
  endfunction

  task automatic model_step();
    m_accepted = 0;
    if (!rst_n) begin
      m_mode = 0; m_el = 0; m_since = 0; m_mute = 0;
      m_acc = RST_ACC; m_pend = RST_ACC; m_df = '0; m_ena = '0; m_tx = 0;
      return;
    end
    m_since = audio_dv ? 0 : ((m_since < WDMAX) ? m_since + 1 : WDMAX);
    m_mute = (m_since == WDMAX);
    m_accepted = cfg_valid && (m_mode == 0 || m_mode == 2);
    case (m_mode)
      0: if (m_accepted) begin
           m_acc = cfg_acc_inc;
           if (cfg_tx_en) begin m_mode = 1; m_el = 0; end
         end
      1: begin
           m_el++;
           if (m_el == D * RC) begin m_mode = 2; m_el = 0; end
         end
      2: if (m_accepted && (!cfg_tx_en || cfg_acc_inc != m_acc)) begin
           m_mode = 3; m_el = 0;
         end
      3: begin
           m_el++;
           if (m_el == D * RC) begin
             m_el = 0;
             if (m_tx) begin m_mode = 4; m_acc = m_pend; end
             else m_mode = 0;
           end
         end
      default: begin
           m_el++;
           if (m_el == ST) begin m_mode = 1; m_el = 0; end
         end
    endcase
    if (m_accepted) begin
      m_df = cfg_df_inc; m_ena = cfg_dac_ena; m_tx = cfg_tx_en; m_pend = cfg_acc_inc;
    end
  endtask

  task automatic check_all();
    int ones;
    case (m_mode)
      1:       ones = m_el / RC;
      2:       ones = D;
      3:       ones = D - m_el / RC;
      default: ones = 0;
    endcase
    chk("state",     state,     m_mode);
    chk("acc_inc",   acc_inc,   m_acc);
    chk("df_inc",    df_inc,    (m_mode == 2 && !m_mute) ? m_df : '0);
    chk("dac_ena",   dac_ena,   m_ena & mask_of(ones));
    chk("mute",      mute,      m_mute);
    chk("cfg_ready", cfg_ready, (m_mode == 0 || m_mode == 2));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    cyc++;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      audio_dv = (aud_per != 0) && ((cyc % aud_per) == 0);
      tick();
    end
  endtask

  task automatic send(input logic [N-1:0] a, input logic [L-1:0] df,
                      input logic [D-1:0] ena, input logic tx);
    bit done = 0;
    cfg_acc_inc = a; cfg_df_inc = df; cfg_dac_ena = ena; cfg_tx_en = tx;
    cfg_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      step(1);
      done = m_accepted;
    end
    cfg_valid = 1'b0;
    chk("accept_timeout", done, 1);
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_acc_inc = '0; cfg_df_inc = '0;
    cfg_dac_ena = '0; cfg_tx_en = 1'b0; audio_dv = 1'b0;
    #2;
    step(2);
    chk("rst_state", state, 0);
    chk("rst_acc", acc_inc, 52429);
    rst_n = 1'b1;

    // Idle without audio: watchdog saturates after 15 cycles.
    step(14);
    chk("idle_mute14", mute, 0);
    step(1);
    chk("idle_mute15", mute, 1);
    chk("idle_ready", cfg_ready, 1);

    // Power-up ramp.
    aud_per = 5;
    send(18'd1000, 12'd300, 4'b1111, 1'b1);
    chk("off_acc", acc_inc, 1000);
    chk("off_to_up", state, 1);
    step(4);
    chk("up_ena1", dac_ena, 4'b1000);
    step(12);
    chk("run_state", state, 2);
    chk("run_df", df_inc, 300);
    chk("run_ena", dac_ena, 4'b1111);

    // In-place update, same carrier.
    send(18'd1000, 12'd500, 4'b0111, 1'b1);
    chk("upd_df", df_inc, 500);
    chk("upd_ena", dac_ena, 4'b0111);
    chk("upd_state", state, 2);

    // Retune: ramp down, settle, ramp up.
    send(18'd2000, 12'd500, 4'b1111, 1'b1);
    chk("rd_df0", df_inc, 0);
    chk("rd_state", state, 3);
    step(16);
    chk("retune_state", state, 4);
    chk("retune_acc", acc_inc, 2000);
    chk("retune_ena", dac_ena, 0);
    step(8);
    chk("reup_state", state, 1);
    step(16);
    chk("rerun_state", state, 2);
    chk("rerun_df", df_inc, 500);

    // Audio loss in RUN.
    aud_per = 0;
    step(15);
    chk("loss_mute", mute, 1);
    chk("loss_df", df_inc, 0);
    audio_dv = 1'b1;
    tick();
    audio_dv = 1'b0;
    chk("resume_mute", mute, 0);
    chk("resume_df", df_inc, 500);

    // Randomized traffic with held valid, sparse/dense audio and occasional reset.
    for (int seg = 0; seg < 8; seg++) begin
      int prob = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 3 : 20);
      for (int i = 0; i < 40; i++) begin
        rst_n = ($urandom_range(0, 99) != 0);
        audio_dv = (prob != 0) && ($urandom_range(0, prob - 1) == 0);
        if (!cfg_valid && $urandom_range(0, 3) == 0) begin
          cfg_acc_inc = ($urandom_range(0, 2) == 0) ? 18'($urandom) :
                        (($urandom_range(0, 1) == 0) ? 18'd2000 : 18'd3000);
          cfg_df_inc  = 12'($urandom);
          cfg_dac_ena = 4'($urandom);
          cfg_tx_en   = ($urandom_range(0, 3) != 0);
          cfg_valid   = 1'b1;
        end
        tick();
        if (m_accepted) cfg_valid = 1'b0;
      end
    end

    // Reset while ramping down, with a configuration held on the input.
    rst_n = 1'b1; cfg_valid = 1'b0; audio_dv = 1'b0;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    aud_per = 5;
    send(18'd1000, 12'd300, 4'b1111, 1'b1);
    step(16);
    send(18'd3000, 12'd300, 4'b1111, 1'b1);
    step(5);
    chk("pre_rst_state", state, 3);
    cfg_acc_inc = 18'd4000; cfg_df_inc = 12'd77; cfg_dac_ena = 4'b1111; cfg_tx_en = 1'b1;
    cfg_valid = 1'b1;
    rst_n = 1'b0;
    step(1);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_acc", acc_inc, 52429);
    chk("mid_rst_df", df_inc, 0);
    chk("mid_rst_ena", dac_ena, 0);
    chk("mid_rst_mute", mute, 0);
    step(1);
    chk("rst_no_accept", acc_inc, 52429);
    cfg_valid = 1'b0;
    rst_n = 1'b1;
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
